// File: rtl/gate_sweep_checker.sv
// Stimulus/response checker for the two-input gate block: sweeps {a,b} through
// 00..11, lets each vector settle, and compares the six gate outputs to a golden table.
//
// state  | meaning
// IDLE   | waiting for start; results of the last sweep held
// DRIVE  | current vector on a/b, settle counter running
// SAMPLE | last settle cycle; resp compared against golden value
// DONE   | one-cycle completion pulse, pass published
module gate_sweep_checker #(
  parameter int unsigned SETTLE   = 2,
  parameter logic [23:0] EXPECTED = 24'h8D65AC
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [5:0] i_resp,
  output logic       o_a,
  output logic       o_b,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [2:0] o_err_count,
  output logic [3:0] o_fail_mask
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] LP_CNT_LAST = 4'(SETTLE - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_vec;
  logic [3:0] r_cnt;
  logic       r_a;
  logic       r_b;
  logic       r_pass;
  logic [2:0] r_err;
  logic [3:0] r_mask;

  logic [5:0] w_exp;
  logic       w_mismatch;
  logic [2:0] w_err_nxt;
  logic [1:0] w_vec_inc;
  logic       w_cnt_last;

  always_comb begin
    w_exp = EXPECTED[5:0];
    case (r_vec)
      2'd0:    w_exp = EXPECTED[5:0];
      2'd1:    w_exp = EXPECTED[11:6];
      2'd2:    w_exp = EXPECTED[17:12];
      default: w_exp = EXPECTED[23:18];
    endcase
  end

  assign w_mismatch = (r_state == S_SAMPLE) && (i_resp != w_exp);
  assign w_err_nxt  = r_err + {2'b00, w_mismatch};
  assign w_vec_inc  = r_vec + 2'd1;
  assign w_cnt_last = (r_cnt == LP_CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_state_nxt = S_DRIVE;
      S_DRIVE:  if (w_cnt_last) w_state_nxt = S_SAMPLE;
      S_SAMPLE: w_state_nxt = (r_vec == 2'd3) ? S_DONE : S_DRIVE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state == S_DRIVE) || (r_state == S_SAMPLE);
    o_done = (r_state == S_DONE);
  end

  // pass is settled on the edge into DONE so it is already valid alongside done
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vec  <= 2'd0;
      r_cnt  <= 4'd0;
      r_a    <= 1'b0;
      r_b    <= 1'b0;
      r_pass <= 1'b0;
      r_err  <= 3'd0;
      r_mask <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_vec  <= 2'd0;
            r_cnt  <= 4'd0;
            r_a    <= 1'b0;
            r_b    <= 1'b0;
            r_pass <= 1'b0;
            r_err  <= 3'd0;
            r_mask <= 4'd0;
          end
        end
        S_DRIVE: begin
          r_cnt <= r_cnt + 4'd1;
        end
        S_SAMPLE: begin
          r_err <= w_err_nxt;
          if (w_mismatch) r_mask[r_vec] <= 1'b1;
          if (r_vec != 2'd3) begin
            r_vec <= w_vec_inc;
            r_cnt <= 4'd0;
            r_a   <= w_vec_inc[1];
            r_b   <= w_vec_inc[0];
          end else begin
            r_pass <= (w_err_nxt == 3'd0);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_a         = r_a;
  assign o_b         = r_b;
  assign o_pass      = r_pass;
  assign o_err_count = r_err;
  assign o_fail_mask = r_mask;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: a behavioural gate block with injectable
// faults feeds one checker at SETTLE=2 and a second at SETTLE=1.
module tb_gate_sweep_checker;

  logic       clk;
  logic       rst_n;
  logic       start0, start1;
  logic [5:0] resp0, resp1;
  logic       a0, b0, busy0, done0, pass0;
  logic       a1, b1, busy1, done1, pass1;
  logic [2:0] err0, err1;
  logic [3:0] mask0, mask1;
  int         fault;
  int         n_vec;
  int         n_miss;

  gate_sweep_checker #(.SETTLE(2)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start0), .i_resp(resp0),
    .o_a(a0), .o_b(b0), .o_busy(busy0), .o_done(done0), .o_pass(pass0),
    .o_err_count(err0), .o_fail_mask(mask0)
  );

  gate_sweep_checker #(.SETTLE(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_resp(resp1),
    .o_a(a1), .o_b(b1), .o_busy(busy1), .o_done(done1), .o_pass(pass1),
    .o_err_count(err1), .o_fail_mask(mask1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] gate_fn(input logic a, input logic b);
    return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
  endfunction

  always_comb begin
    resp0 = gate_fn(a0, b0);
    if (fault == 1)      resp0[0] = 1'b0;
    else if (fault == 2) resp0 = ~gate_fn(a0, b0);
  end

  always_comb resp1 = gate_fn(a1, b1);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full SETTLE=2 sweep on dut0; vector k occupies cycles 3k+1..3k+3, done in cycle 13.
  task automatic sweep0(input string name, input int extra_start, input logic exp_pass,
                        input logic [2:0] exp_err, input logic [3:0] exp_mask);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      if (c <= 12) begin
        check($sformatf("%s c%0d busy", name, c), 8'(busy0), 8'd1);
        check($sformatf("%s c%0d ab", name, c), 8'({a0, b0}), 8'((c - 1) / 3));
        check($sformatf("%s c%0d done", name, c), 8'(done0), 8'd0);
      end else begin
        check($sformatf("%s done", name), 8'(done0), 8'd1);
        check($sformatf("%s done busy", name), 8'(busy0), 8'd0);
        check($sformatf("%s done ab", name), 8'({a0, b0}), 8'd3);
        check($sformatf("%s pass", name), 8'(pass0), 8'(exp_pass));
        check($sformatf("%s err_count", name), 8'(err0), 8'(exp_err));
        check($sformatf("%s fail_mask", name), 8'(mask0), 8'(exp_mask));
      end
      start0 = (c == extra_start);
      tick();
    end
    start0 = 1'b0;
    check($sformatf("%s post done", name), 8'(done0), 8'd0);
    check($sformatf("%s post busy", name), 8'(busy0), 8'd0);
    check($sformatf("%s post pass", name), 8'(pass0), 8'(exp_pass));
    check($sformatf("%s post ab", name), 8'({a0, b0}), 8'd3);
    check($sformatf("%s post mask", name), 8'(mask0), 8'(exp_mask));
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    fault  = 0;
    rst_n  = 1'b0;
    start0 = 1'b1;
    start1 = 1'b1;

    // reset with start asserted
    tick();
    tick();
    check("rst ab", 8'({a0, b0}), 8'd0);
    check("rst busy", 8'(busy0), 8'd0);
    check("rst done", 8'(done0), 8'd0);
    check("rst pass", 8'(pass0), 8'd0);
    check("rst err", 8'(err0), 8'd0);
    check("rst mask", 8'(mask0), 8'd0);
    check("rst1 busy", 8'(busy1), 8'd0);
    check("rst1 ab", 8'({a1, b1}), 8'd0);
    rst_n  = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    tick();
    check("idle busy", 8'(busy0), 8'd0);

    sweep0("ideal", -1, 1'b1, 3'd0, 4'b0000);

    fault = 1;
    sweep0("stuck0", -1, 1'b0, 3'd1, 4'b1000);

    fault = 2;
    sweep0("invert", 6, 1'b0, 3'd4, 4'b1111);

    // reset mid-sweep during vector 2
    fault  = 0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    check("abort c8 ab", 8'({a0, b0}), 8'd2);
    check("abort c8 busy", 8'(busy0), 8'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort busy", 8'(busy0), 8'd0);
    check("abort ab", 8'({a0, b0}), 8'd0);
    check("abort done", 8'(done0), 8'd0);
    check("abort pass", 8'(pass0), 8'd0);
    check("abort err", 8'(err0), 8'd0);
    for (int c = 10; c <= 15; c++) begin
      tick();
      check($sformatf("abort c%0d done", c), 8'(done0), 8'd0);
      check($sformatf("abort c%0d busy", c), 8'(busy0), 8'd0);
    end
    sweep0("resweep", -1, 1'b1, 3'd0, 4'b0000);

    // SETTLE=1 with start held high: done in cycle 9, restart in cycle 11
    start1 = 1'b1;
    tick();
    for (int c = 1; c <= 10; c++) begin
      if (c <= 8) begin
        check($sformatf("s1 c%0d busy", c), 8'(busy1), 8'd1);
        check($sformatf("s1 c%0d ab", c), 8'({a1, b1}), 8'((c - 1) / 2));
        check($sformatf("s1 c%0d done", c), 8'(done1), 8'd0);
      end else if (c == 9) begin
        check("s1 done", 8'(done1), 8'd1);
        check("s1 done busy", 8'(busy1), 8'd0);
        check("s1 pass", 8'(pass1), 8'd1);
        check("s1 err", 8'(err1), 8'd0);
        check("s1 mask", 8'(mask1), 8'd0);
      end else begin
        check("s1 c10 busy", 8'(busy1), 8'd0);
        check("s1 c10 done", 8'(done1), 8'd0);
        check("s1 c10 pass", 8'(pass1), 8'd1);
      end
      tick();
    end
    check("s1 c11 busy", 8'(busy1), 8'd1);
    check("s1 c11 ab", 8'({a1, b1}), 8'd0);
    check("s1 c11 pass", 8'(pass1), 8'd0);
    check("s1 c11 err", 8'(err1), 8'd0);
    start1 = 1'b0;
    for (int c = 11; c < 19; c++) tick();
    check("s1 c19 done", 8'(done1), 8'd1);
    check("s1 c19 pass", 8'(pass1), 8'd1);
    tick();
    tick();
    check("s1 c21 busy", 8'(busy1), 8'd0);
    check("s1 c21 done", 8'(done1), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
